// File: rtl/nco_est_pkg.sv
// Shared types and elaboration-time helpers for the NCO frequency estimator:
// CORDIC FSM states, accumulator sizing and the arctangent table generator.
package nco_est_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PREROT = 2'd1,
        ST_ITER   = 2'd2,
        ST_OUT    = 2'd3
    } cordic_state_t;

    // Width of the window sums: a (2*DATA_W+1)-bit product summed 2^LOG2_AVG times.
    function automatic int sum_w(input int data_w, input int log2_avg);
        return 2 * data_w + 1 + log2_avg;
    endfunction

    // Right shift that maps a window sum onto CORDIC_W-2 bits, leaving 2 bits for CORDIC gain.
    function automatic int norm_shift(input int data_w, input int log2_avg, input int cordic_w);
        return sum_w(data_w, log2_avg) - (cordic_w - 2);
    endfunction

    // round(atan(2^-i) * 2^phase_w / 2pi); Taylor series keeps this to basic real arithmetic.
    function automatic longint atan_lsb(input int i, input int phase_w);
        real pi_c, x, x2, term, acc, sgn, scale;
        pi_c = 3.14159265358979323846;
        acc  = 0.0;
        if (i == 0) begin
            acc = pi_c / 4.0;
        end else begin
            x = 1.0;
            for (int k = 0; k < i; k++) x = x / 2.0;
            x2   = x * x;
            term = x;
            sgn  = 1.0;
            for (int k = 0; k < 40; k++) begin
                acc  = acc + sgn * term / real'(2 * k + 1);
                term = term * x2;
                sgn  = -sgn;
            end
        end
        scale = 1.0;
        for (int k = 0; k < phase_w; k++) scale = scale * 2.0;
        return longint'($rtoi(acc * scale / (2.0 * pi_c) + 0.5));
    endfunction

endpackage

// File: rtl/nco_freq_estimator_if.sv
// Sample stream into the estimator and the estimate/status coming back out.
interface nco_freq_estimator_if #(
    parameter int DATA_W  = 14,
    parameter int PHASE_W = 24
);
    import nco_est_pkg::*;

    // No backpressure: a sample transfers on every enabled edge with in_valid high.
    // est_valid is a one-enabled-cycle pulse; phi_est holds until the next pulse.
    logic               in_valid;
    logic [DATA_W-1:0]  fsin_i;
    logic [DATA_W-1:0]  fcos_i;
    logic [PHASE_W-1:0] phi_est;
    logic               est_valid;
    logic               busy;
    cordic_state_t      dbg_state;

    modport master (
        output in_valid, fsin_i, fcos_i,
        input  phi_est, est_valid, busy, dbg_state
    );

    modport slave (
        input  in_valid, fsin_i, fcos_i,
        output phi_est, est_valid, busy, dbg_state
    );
endinterface

// File: rtl/nco_est_cordic_vec.sv
// Iterative vectoring CORDIC: converts a loaded (x, y) vector into an angle
// where 2^PHASE_W is one full turn.
module nco_est_cordic_vec
    import nco_est_pkg::*;
#(
    parameter int PHASE_W      = 24,
    parameter int CORDIC_W     = 32,
    parameter int CORDIC_ITERS = 20
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clken,
    input  logic                       start,
    input  logic signed [CORDIC_W-1:0] x_in,
    input  logic signed [CORDIC_W-1:0] y_in,
    output logic [PHASE_W-1:0]         angle_out,
    output logic                       done,
    output logic                       busy,
    output cordic_state_t              state
);
    localparam int IW = (CORDIC_ITERS > 1) ? $clog2(CORDIC_ITERS) : 1;
    localparam logic [IW-1:0] LAST_ITER = IW'(CORDIC_ITERS - 1);
    localparam logic [PHASE_W-1:0] HALF_TURN = PHASE_W'(1) << (PHASE_W - 1);

    typedef logic [CORDIC_ITERS-1:0][PHASE_W-1:0] atan_tab_t;

    function automatic atan_tab_t gen_atan();
        atan_tab_t t;
        for (int i = 0; i < CORDIC_ITERS; i++) t[i] = PHASE_W'(atan_lsb(i, PHASE_W));
        return t;
    endfunction

    localparam atan_tab_t ATAN = gen_atan();

    if (CORDIC_ITERS > PHASE_W - 2) begin : g_bad_iters
        $error("CORDIC_ITERS must not exceed PHASE_W-2");
    end

    logic signed [CORDIC_W-1:0] x, y;
    logic [PHASE_W-1:0]         angle;
    logic [IW-1:0]              iter;
    logic                       y_pos, y_neg;

    // d = sign(y) with sign(0) = 0, so a zero vector never accumulates angle.
    assign y_neg = y[CORDIC_W-1];
    assign y_pos = !y[CORDIC_W-1] && (y != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            x         <= '0;
            y         <= '0;
            angle     <= '0;
            iter      <= '0;
            angle_out <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else if (clken) begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        x     <= x_in;
                        y     <= y_in;
                        busy  <= 1'b1;
                        state <= ST_PREROT;
                    end
                end
                ST_PREROT: begin
                    if (x[CORDIC_W-1]) begin
                        x     <= -x;
                        y     <= -y;
                        angle <= HALF_TURN;
                    end else begin
                        angle <= '0;
                    end
                    iter  <= '0;
                    state <= ST_ITER;
                end
                ST_ITER: begin
                    if (y_pos) begin
                        x     <= x + (y >>> iter);
                        y     <= y - (x >>> iter);
                        angle <= angle + ATAN[iter];
                    end else if (y_neg) begin
                        x     <= x - (y >>> iter);
                        y     <= y + (x >>> iter);
                        angle <= angle - ATAN[iter];
                    end
                    if (iter == LAST_ITER) state <= ST_OUT;
                    else                   iter  <= iter + IW'(1);
                end
                ST_OUT: begin
                    angle_out <= angle;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/nco_freq_estimator.sv
// Estimates an NCO phase increment: conjugate products of successive samples
// are summed over a window and the summed vector's angle is taken by CORDIC.
module nco_freq_estimator
    import nco_est_pkg::*;
#(
    parameter int DATA_W       = 14,
    parameter int PHASE_W      = 24,
    parameter int LOG2_AVG     = 6,
    parameter int CORDIC_W     = 32,
    parameter int CORDIC_ITERS = 20
) (
    input logic                 clk,
    input logic                 reset,
    input logic                 clken,
    nco_freq_estimator_if.slave bus
);
    localparam int P_W        = 2 * DATA_W;
    localparam int R_W        = 2 * DATA_W + 1;
    localparam int SUM_W      = sum_w(DATA_W, LOG2_AVG);
    localparam int NORM_SHIFT = norm_shift(DATA_W, LOG2_AVG, CORDIC_W);

    if ((1 << LOG2_AVG) < CORDIC_ITERS + 4) begin : g_bad_window
        $error("window 2^LOG2_AVG must be at least CORDIC_ITERS+4");
    end
    if (NORM_SHIFT < 0) begin : g_bad_norm
        $error("CORDIC_W too wide for the window sum width");
    end

    logic signed [DATA_W-1:0]   fcos, fsin, c_prev, s_prev;
    logic                       have_prev;
    logic signed [P_W-1:0]      p_cc, p_ss, p_sc, p_cs;
    logic                       v1, v2;
    logic signed [R_W-1:0]      re, im;
    logic signed [SUM_W-1:0]    acc_re, acc_im, sum_re, sum_im;
    logic [LOG2_AVG-1:0]        win_cnt;
    logic                       win_last;
    logic signed [CORDIC_W-1:0] cx, cy;

    assign fcos = bus.fcos_i;
    assign fsin = bus.fsin_i;

    // The window's last product bypasses the accumulator straight into the CORDIC.
    assign sum_re   = acc_re + SUM_W'(re);
    assign sum_im   = acc_im + SUM_W'(im);
    assign win_last = v2 && (win_cnt == '1);
    assign cx       = CORDIC_W'(sum_re >>> NORM_SHIFT);
    assign cy       = CORDIC_W'(sum_im >>> NORM_SHIFT);

    always_ff @(posedge clk) begin
        if (reset) begin
            have_prev <= 1'b0;
            c_prev    <= '0;
            s_prev    <= '0;
            v1        <= 1'b0;
            p_cc      <= '0;
            p_ss      <= '0;
            p_sc      <= '0;
            p_cs      <= '0;
            v2        <= 1'b0;
            re        <= '0;
            im        <= '0;
            acc_re    <= '0;
            acc_im    <= '0;
            win_cnt   <= '0;
        end else if (clken) begin
            v1 <= bus.in_valid && have_prev;
            if (bus.in_valid) begin
                p_cc      <= P_W'(fcos) * P_W'(c_prev);
                p_ss      <= P_W'(fsin) * P_W'(s_prev);
                p_sc      <= P_W'(fsin) * P_W'(c_prev);
                p_cs      <= P_W'(fcos) * P_W'(s_prev);
                c_prev    <= fcos;
                s_prev    <= fsin;
                have_prev <= 1'b1;
            end
            v2 <= v1;
            if (v1) begin
                re <= R_W'(p_cc) + R_W'(p_ss);
                im <= R_W'(p_sc) - R_W'(p_cs);
            end
            if (v2) begin
                if (win_last) begin
                    acc_re  <= '0;
                    acc_im  <= '0;
                    win_cnt <= '0;
                end else begin
                    acc_re  <= sum_re;
                    acc_im  <= sum_im;
                    win_cnt <= win_cnt + LOG2_AVG'(1);
                end
            end
        end
    end

    logic [PHASE_W-1:0] angle;
    logic               done, cordic_busy;
    cordic_state_t      cordic_state;

    nco_est_cordic_vec #(
        .PHASE_W      (PHASE_W),
        .CORDIC_W     (CORDIC_W),
        .CORDIC_ITERS (CORDIC_ITERS)
    ) u_cordic (
        .clk       (clk),
        .reset     (reset),
        .clken     (clken),
        .start     (win_last),
        .x_in      (cx),
        .y_in      (cy),
        .angle_out (angle),
        .done      (done),
        .busy      (cordic_busy),
        .state     (cordic_state)
    );

    assign bus.phi_est   = angle;
    assign bus.est_valid = done;
    assign bus.busy      = cordic_busy;
    assign bus.dbg_state = cordic_state;
endmodule

// File: tb/tb_nco_freq_estimator.sv
// Scoreboard bench for nco_freq_estimator: directed tones with known phase
// increments, expected estimates queued at stimulus time and checked on est_valid.
module tb_nco_freq_estimator;
    import nco_est_pkg::*;

    localparam int  DATA_W       = 14;
    localparam int  PHASE_W      = 24;
    localparam int  LOG2_AVG     = 6;
    localparam int  CORDIC_W     = 32;
    localparam int  CORDIC_ITERS = 20;
    localparam int  WIN          = 1 << LOG2_AVG;
    localparam int  LAT          = 4 + CORDIC_ITERS;
    localparam real PI           = 3.14159265358979323846;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    logic clken;

    always #5 clk = ~clk;

    nco_freq_estimator_if #(.DATA_W(DATA_W), .PHASE_W(PHASE_W)) bus ();

    nco_freq_estimator #(
        .DATA_W       (DATA_W),
        .PHASE_W      (PHASE_W),
        .LOG2_AVG     (LOG2_AVG),
        .CORDIC_W     (CORDIC_W),
        .CORDIC_ITERS (CORDIC_ITERS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .clken (clken),
        .bus   (bus)
    );

    // ---------------- scoreboard state ----------------
    logic [PHASE_W-1:0] exp_q[$];
    int                 due_q[$];
    int                 tol_q[$];
    int                 n_checks = 0;
    int                 n_errors = 0;
    int                 ecyc     = 0;
    logic [PHASE_W-1:0] cur_exp;
    int                 cur_tol;
    bit                 primed;
    int                 prod_cnt;

    task automatic check(input string name, input longint act, input longint req, input bit ok);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int rnd(input real v);
        if (v >= 0.0) return $rtoi(v + 0.5);
        else          return -$rtoi(-v + 0.5);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step(input bit en, input bit v, input int c, input int s);
        @(negedge clk);
        clken        = en;
        bus.in_valid = v;
        bus.fcos_i   = DATA_W'(c);
        bus.fsin_i   = DATA_W'(s);
        if (en && v) begin
            if (primed) begin
                prod_cnt++;
                if (prod_cnt % WIN == 0) begin
                    exp_q.push_back(cur_exp);
                    due_q.push_back(ecyc + 1 + LAT);
                    tol_q.push_back(cur_tol);
                end
            end
            primed = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b1;
        clken        = 1'b1;
        bus.in_valid = 1'b0;
        bus.fcos_i   = '0;
        bus.fsin_i   = '0;
        exp_q.delete();
        due_q.delete();
        tol_q.delete();
        primed   = 1'b0;
        prod_cnt = 0;
        @(posedge clk);
        #1;
        check("reset phi_est", bus.phi_est, 0, bus.phi_est == '0);
        check("reset est_valid", bus.est_valid, 0, bus.est_valid == 1'b0);
        check("reset busy", bus.busy, 0, bus.busy == 1'b0);
        check("reset state", bus.dbg_state, ST_IDLE, bus.dbg_state == ST_IDLE);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_tone(input logic [PHASE_W-1:0] inc, input logic [PHASE_W-1:0] ph0,
                            input int amp, input int nsamp, input int gap_pct,
                            input int off_pct, input int tol);
        logic [PHASE_W-1:0] ph;
        int  used;
        real a;
        bit  en, v;
        ph      = ph0;
        used    = 0;
        cur_exp = (amp == 0) ? '0 : inc;
        cur_tol = tol;
        while (used < nsamp) begin
            en = ($urandom_range(99) >= off_pct);
            v  = ($urandom_range(99) >= gap_pct);
            a  = 2.0 * PI * real'(ph) / real'(longint'(1) << PHASE_W);
            step(en, v, rnd(real'(amp) * $cos(a)), rnd(real'(amp) * $sin(a)));
            if (en && v) begin
                ph = ph + inc;
                used++;
            end
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            idle(1);
            k++;
        end
        check("drain pending estimates", exp_q.size(), 0, exp_q.size() == 0);
        idle(40);
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [PHASE_W-1:0]        e;
        logic signed [PHASE_W-1:0] diff;
        int                        d, t, ad;
        forever begin
            @(posedge clk);
            if (clken === 1'b1) begin
                ecyc++;
                #1;
                if (bus.est_valid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected est_valid", bus.phi_est, 0, 1'b0);
                    end else begin
                        e    = exp_q.pop_front();
                        d    = due_q.pop_front();
                        t    = tol_q.pop_front();
                        diff = $signed(bus.phi_est - e);
                        ad   = (diff < 0) ? -int'(diff) : int'(diff);
                        check("phi_est", bus.phi_est, e, ad <= t);
                        check("est_valid timing", ecyc, d, ecyc == d);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int k;
        reset        = 1'b1;
        clken        = 1'b0;
        bus.in_valid = 1'b0;
        bus.fcos_i   = '0;
        bus.fsin_i   = '0;
        primed       = 1'b0;
        prod_cnt     = 0;

        do_reset();
        run_tone(24'h4AAAAB, 24'h123456, 8191, 3 * WIN + 1, 0, 0, 64);
        drain();

        do_reset();
        run_tone(24'h000000, 24'h0F0F0F, 8191, 2 * WIN + 1, 0, 0, 64);
        drain();

        do_reset();
        run_tone(24'hC00000, 24'h000000, 8191, 2 * WIN + 1, 0, 0, 64);
        drain();

        do_reset();
        run_tone(24'h800000, 24'h2A0000, 8191, 2 * WIN + 1, 0, 0, 64);
        drain();

        do_reset();
        run_tone(24'h4AAAAB, 24'h123456, 8191, 3 * WIN + 11, 30, 20, 64);
        drain();

        // Abort an estimate mid-CORDIC, then require a full fresh window.
        do_reset();
        run_tone(24'h4AAAAB, 24'h333333, 8191, WIN + 1, 0, 0, 64);
        k = 0;
        while (bus.busy !== 1'b1 && k < 10) begin
            idle(1);
            k++;
        end
        check("busy before abort", bus.busy, 1, bus.busy === 1'b1);
        idle(3);
        do_reset();
        run_tone(24'h4AAAAB, 24'h333333, 8191, WIN + 1, 0, 0, 64);
        drain();

        // All-zero samples continue the same stream; estimate must fall to 0.
        run_tone(24'h000000, 24'h000000, 0, 2 * WIN, 0, 0, 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
